// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory (write address / write data / read address / read data
// stb-rdy channels) among N requesters. Each request channel has its own round-robin
// pointer; read responses are steered back to their issuer through a 2-deep in-order ID FIFO.
// All request paths are combinational, so no latency is added to the memory's own.
module memory_arbiter #(
  parameter  int N     = 4,
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH),
  localparam int IW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       s_wa_stb,
  input  logic [N*AW-1:0]    s_wa_dat,
  output logic [N-1:0]       s_wa_rdy,
  input  logic [N-1:0]       s_wd_stb,
  input  logic [N*WIDTH-1:0] s_wd_dat,
  output logic [N-1:0]       s_wd_rdy,
  input  logic [N-1:0]       s_ra_stb,
  input  logic [N*AW-1:0]    s_ra_dat,
  output logic [N-1:0]       s_ra_rdy,
  output logic [N-1:0]       m_rd_stb,
  output logic [WIDTH-1:0]   m_rd_dat,
  input  logic [N-1:0]       m_rd_rdy,
  output logic               m_wa_stb,
  output logic [AW-1:0]      m_wa_dat,
  input  logic               m_wa_rdy,
  output logic               m_wd_stb,
  output logic [WIDTH-1:0]   m_wd_dat,
  input  logic               m_wd_rdy,
  output logic               m_ra_stb,
  output logic [AW-1:0]      m_ra_dat,
  input  logic               m_ra_rdy,
  input  logic               s_rd_stb,
  input  logic [WIDTH-1:0]   s_rd_dat,
  output logic               s_rd_rdy
);

  localparam int unsigned NU = N;

  logic [IW-1:0] r_wptr;
  logic [IW-1:0] r_rptr;
  logic [IW-1:0] r_id [2];
  logic          r_head;
  logic [1:0]    r_count;

  logic [N-1:0]  w_wr_elig;
  logic          w_wr_any;
  logic          w_rd_any;
  logic [IW-1:0] w_wr_win;
  logic [IW-1:0] w_rd_win;
  logic [IW-1:0] w_wr_next;
  logic [IW-1:0] w_rd_next;
  logic [IW-1:0] w_head_id;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_pop;

  assign w_wr_elig = s_wa_stb & s_wd_stb;
  assign w_full    = (r_count == 2'd2);
  assign w_empty   = (r_count == 2'd0);
  assign w_head_id = r_id[r_head];

  // Write round-robin: first eligible requester at or after r_wptr, wrapping
  always_comb begin
    logic [IW-1:0] w_idx;
    w_idx    = '0;
    w_wr_any = 1'b0;
    w_wr_win = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      w_idx = IW'((32'(r_wptr) + k) % NU);
      if (!w_wr_any && w_wr_elig[w_idx]) begin
        w_wr_any = 1'b1;
        w_wr_win = w_idx;
      end
    end
  end

  // Read round-robin: first requesting reader at or after r_rptr, wrapping
  always_comb begin
    logic [IW-1:0] w_idx;
    w_idx    = '0;
    w_rd_any = 1'b0;
    w_rd_win = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      w_idx = IW'((32'(r_rptr) + k) % NU);
      if (!w_rd_any && s_ra_stb[w_idx]) begin
        w_rd_any = 1'b1;
        w_rd_win = w_idx;
      end
    end
  end

  assign w_wr_next = (w_wr_win == IW'(N - 1)) ? '0 : w_wr_win + 1'b1;
  assign w_rd_next = (w_rd_win == IW'(N - 1)) ? '0 : w_rd_win + 1'b1;

  // Write channel: forward the winner's address/data, ready only to the winner
  always_comb begin
    m_wa_stb = w_wr_any;
    m_wd_stb = w_wr_any;
    m_wa_dat = s_wa_dat[32'(w_wr_win) * AW +: AW];
    m_wd_dat = s_wd_dat[32'(w_wr_win) * WIDTH +: WIDTH];
    s_wa_rdy = '0;
    if (w_wr_any) s_wa_rdy[w_wr_win] = m_wa_rdy & m_wd_rdy;
  end

  assign s_wd_rdy = s_wa_rdy;
  assign w_wr_acc = m_wa_stb & m_wa_rdy & m_wd_rdy;

  // Read address channel: issue only while the ID FIFO has room for the response tag
  always_comb begin
    m_ra_stb = w_rd_any & ~w_full;
    m_ra_dat = s_ra_dat[32'(w_rd_win) * AW +: AW];
    s_ra_rdy = '0;
    if (w_rd_any) s_ra_rdy[w_rd_win] = m_ra_rdy & ~w_full;
  end

  assign w_rd_acc = m_ra_stb & m_ra_rdy;

  // Response routing: steer memory read data to the requester at the FIFO head
  always_comb begin
    m_rd_dat = s_rd_dat;
    m_rd_stb = '0;
    if (s_rd_stb && !w_empty) m_rd_stb[w_head_id] = 1'b1;
    s_rd_rdy = ~w_empty & m_rd_rdy[w_head_id];
  end

  assign w_pop = s_rd_stb & s_rd_rdy;

  // Pointers and ID FIFO; the write slot is head+count mod 2 since depth is 2
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_head  <= 1'b0;
      r_count <= 2'd0;
      r_id[0] <= '0;
      r_id[1] <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= w_wr_next;
      if (w_rd_acc) begin
        r_rptr                   <= w_rd_next;
        r_id[r_head ^ r_count[0]] <= w_rd_win;
      end
      if (w_pop) r_head <= ~r_head;
      case ({w_rd_acc, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: drives memory_arbiter with directed and random traffic against a
// behavioural memory, and compares every output each cycle with a queue-based model.
module tb_memory_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 16;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       s_wa_stb, s_wa_rdy, s_wd_stb, s_wd_rdy, s_ra_stb, s_ra_rdy;
  logic [N*AW-1:0]    s_wa_dat, s_ra_dat;
  logic [N*WIDTH-1:0] s_wd_dat;
  logic [N-1:0]       m_rd_stb, m_rd_rdy;
  logic [WIDTH-1:0]   m_rd_dat;
  logic               m_wa_stb, m_wa_rdy, m_wd_stb, m_wd_rdy, m_ra_stb, m_ra_rdy;
  logic [AW-1:0]      m_wa_dat, m_ra_dat;
  logic [WIDTH-1:0]   m_wd_dat;
  logic               s_rd_stb, s_rd_rdy;
  logic [WIDTH-1:0]   s_rd_dat;

  always #5 clk = ~clk;

  memory_arbiter #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_wa_stb(s_wa_stb), .s_wa_dat(s_wa_dat), .s_wa_rdy(s_wa_rdy),
    .s_wd_stb(s_wd_stb), .s_wd_dat(s_wd_dat), .s_wd_rdy(s_wd_rdy),
    .s_ra_stb(s_ra_stb), .s_ra_dat(s_ra_dat), .s_ra_rdy(s_ra_rdy),
    .m_rd_stb(m_rd_stb), .m_rd_dat(m_rd_dat), .m_rd_rdy(m_rd_rdy),
    .m_wa_stb(m_wa_stb), .m_wa_dat(m_wa_dat), .m_wa_rdy(m_wa_rdy),
    .m_wd_stb(m_wd_stb), .m_wd_dat(m_wd_dat), .m_wd_rdy(m_wd_rdy),
    .m_ra_stb(m_ra_stb), .m_ra_dat(m_ra_dat), .m_ra_rdy(m_ra_rdy),
    .s_rd_stb(s_rd_stb), .s_rd_dat(s_rd_dat), .s_rd_rdy(s_rd_rdy)
  );

  // behavioural memory (acts on what the arbiter actually presents)
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] mem_q [$];
  bit               spur;

  // reference model
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int               wptr, rptr;
  int               exp_id [$];
  logic [WIDTH-1:0] exp_dat [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit rr_pick(input logic [N-1:0] req, input int ptr, output int win);
    win = 0;
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) begin
        win = (ptr + k) % N;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic idle();
    s_wa_stb = '0; s_wd_stb = '0; s_ra_stb = '0; spur = 1'b0; rst = 1'b0;
  endtask

  // One clock: present memory output, check every DUT output, advance memory and model
  task automatic step();
    logic [N-1:0]     e_vec;
    int               ww, rw, h;
    bit               wf, rf, full, empty, w_acc, r_acc, pop;
    logic [AW-1:0]    waddr, raddr, a_wa, a_ra;
    logic [WIDTH-1:0] wdata, rdv, a_wd;
    bit               a_wr, a_rd, a_pop;
    waddr = '0; raddr = '0; wdata = '0;
    s_rd_stb = (mem_q.size() > 0) ? 1'b1 : spur;
    s_rd_dat = (mem_q.size() > 0) ? mem_q[0] : WIDTH'($urandom);
    #1;
    wf = rr_pick(s_wa_stb & s_wd_stb, wptr, ww);
    chk("wa_stb", m_wa_stb, wf);
    chk("wd_stb", m_wd_stb, wf);
    if (wf) begin
      waddr = s_wa_dat[ww*AW +: AW];
      wdata = s_wd_dat[ww*WIDTH +: WIDTH];
      chk("wa_dat", m_wa_dat, waddr);
      chk("wd_dat", m_wd_dat, wdata);
    end
    e_vec = '0;
    if (wf) e_vec[ww] = m_wa_rdy & m_wd_rdy;
    chk("wa_rdy", s_wa_rdy, e_vec);
    chk("wd_rdy", s_wd_rdy, e_vec);
    w_acc = wf && m_wa_rdy && m_wd_rdy;

    full  = (exp_id.size() == 2);
    empty = (exp_id.size() == 0);
    rf = rr_pick(s_ra_stb, rptr, rw);
    chk("ra_stb", m_ra_stb, rf && !full);
    if (rf && !full) begin
      raddr = s_ra_dat[rw*AW +: AW];
      chk("ra_dat", m_ra_dat, raddr);
    end
    e_vec = '0;
    if (rf && !full) e_vec[rw] = m_ra_rdy;
    chk("ra_rdy", s_ra_rdy, e_vec);
    r_acc = rf && !full && m_ra_rdy;

    h = empty ? 0 : exp_id[0];
    e_vec = '0;
    if (s_rd_stb && !empty) e_vec[h] = 1'b1;
    chk("rd_stb", m_rd_stb, e_vec);
    chk("rd_rdy", s_rd_rdy, !empty && m_rd_rdy[h]);
    if (s_rd_stb && !empty) chk("rd_dat", m_rd_dat, exp_dat[0]);
    pop = s_rd_stb && !empty && m_rd_rdy[h];

    a_wr  = m_wa_stb && m_wa_rdy && m_wd_rdy;
    a_wa  = m_wa_dat;
    a_wd  = m_wd_dat;
    a_rd  = m_ra_stb && m_ra_rdy;
    a_ra  = m_ra_dat;
    a_pop = s_rd_stb && s_rd_rdy && (mem_q.size() > 0);

    @(posedge clk);
    if (rst) begin
      mem_q.delete();
      exp_id.delete();
      exp_dat.delete();
      wptr = 0;
      rptr = 0;
    end else begin
      rdv = mem[a_ra];
      if (a_pop) void'(mem_q.pop_front());
      if (a_rd) mem_q.push_back(rdv);
      if (a_wr) mem[a_wa] = a_wd;
      if (pop) begin
        void'(exp_id.pop_front());
        void'(exp_dat.pop_front());
      end
      if (r_acc) begin
        exp_id.push_back(rw);
        exp_dat.push_back(ref_mem[raddr]);
        rptr = (rw + 1) % N;
      end
      if (w_acc) begin
        ref_mem[waddr] = wdata;
        wptr = (ww + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_drive(input int pw, input int pr, input int prdy);
    for (int i = 0; i < N; i++) begin
      s_wa_stb[i] = ($urandom_range(0, 99) < pw);
      s_wd_stb[i] = ($urandom_range(0, 99) < 80) ? s_wa_stb[i] : 1'($urandom_range(0, 1));
      s_ra_stb[i] = ($urandom_range(0, 99) < pr);
      m_rd_rdy[i] = ($urandom_range(0, 99) < prdy);
      s_wa_dat[i*AW +: AW]       = AW'($urandom_range(0, 7));
      s_ra_dat[i*AW +: AW]       = AW'($urandom_range(0, 7));
      s_wd_dat[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
    m_wa_rdy = ($urandom_range(0, 3) != 0);
    m_wd_rdy = ($urandom_range(0, 3) != 0);
    m_ra_rdy = ($urandom_range(0, 3) != 0);
    spur     = ($urandom_range(0, 9) == 0);
    rst      = ($urandom_range(0, 149) == 0);
    if (rst) begin
      s_wa_stb = '0; s_wd_stb = '0; s_ra_stb = '0;
    end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      mem[a]     = WIDTH'($urandom);
      ref_mem[a] = mem[a];
    end
    mem[5] = 16'h1234; ref_mem[5] = 16'h1234;
    idle();
    s_wa_dat = '0; s_wd_dat = '0; s_ra_dat = '0;
    m_rd_rdy = '1; m_wa_rdy = 1'b1; m_wd_rdy = 1'b1; m_ra_rdy = 1'b1;
    s_rd_stb = 1'b0; s_rd_dat = '0;
    wptr = 0; rptr = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();                                   // reset state with no requests

    // req 0 reads mem[5]
    s_ra_stb = 4'b0001; s_ra_dat[0 +: AW] = 8'h05;
    step();
    idle();
    repeat (2) step();

    // all requesters read every cycle
    for (int i = 0; i < N; i++) s_ra_dat[i*AW +: AW] = AW'(i + 1);
    s_ra_stb = '1;
    repeat (12) step();
    idle();
    repeat (3) step();

    // req 1 stalls its response: FIFO fills, reads blocked, then drain
    m_rd_rdy = 4'b1101;
    s_ra_stb = 4'b0010;
    step();
    s_ra_stb = '1;
    repeat (6) step();
    idle();
    m_rd_rdy = '1;
    repeat (4) step();

    // reqs 0 and 2 write address 3 together, then read back
    s_wa_stb = 4'b0101; s_wd_stb = 4'b0101;
    s_wa_dat[0*AW +: AW] = 8'h03; s_wd_dat[0*WIDTH +: WIDTH] = 16'hAAAA;
    s_wa_dat[2*AW +: AW] = 8'h03; s_wd_dat[2*WIDTH +: WIDTH] = 16'h5555;
    repeat (2) step();
    idle();
    s_ra_stb = 4'b0010; s_ra_dat[1*AW +: AW] = 8'h03;
    step();
    idle();
    repeat (2) step();

    // reset with two reads outstanding
    m_rd_rdy = '0;
    s_ra_stb = 4'b0101;
    repeat (3) step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_rd_rdy = '1;
    s_ra_stb = 4'b1100;
    repeat (2) step();
    idle();
    repeat (3) step();

    // req 3 writes and req 1 reads the same address in the same cycle
    s_wa_stb = 4'b1000; s_wd_stb = 4'b1000;
    s_wa_dat[3*AW +: AW] = 8'h09; s_wd_dat[3*WIDTH +: WIDTH] = 16'hBEEF;
    s_ra_stb = 4'b0010; s_ra_dat[1*AW +: AW] = 8'h09;
    step();
    idle();
    step();
    s_ra_stb = 4'b0010;
    step();
    idle();
    repeat (2) step();

    // randomized traffic with varied pressure
    for (int seg = 0; seg < 6; seg++) begin
      for (int c = 0; c < 300; c++) begin
        rand_drive(20 + seg * 12, 30 + seg * 10, 100 - seg * 15);
        step();
      end
    end
    idle();
    m_rd_rdy = '1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
